height_filter: RTL and testbench

// Sequential, parametrised successor to the combinational height stage.
// - Accepts a stream of sensor distance samples and converts each to height (ground - distance).
// - Smooths heights with a 2^AVG_LOG2-sample moving average.
// - Tracks the peak height.
// - Supports run-time ground calibration: the mounting distance is measured, not hard-coded.
// - Sits between the distance converter and the display/BCD stage.
//

---
 rtl/height_filter.sv | 185 ++++++++++++++++++
 tb/tb_height_filter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/height_filter.sv
// height_filter: converts a stream of distance samples into heights above a
// run-time calibrated ground. The heights are smoothed with a 2^AVG_LOG2-sample
// moving average, and the peak of the smoothed height is tracked.
// Two states:
//   RUN - filtering.
//   CAL - averaging raw distances to find a new ground distance.
module height_filter #(
    parameter int WIDTH          = 8,
    parameter int DEFAULT_GROUND = 72,
    parameter int AVG_LOG2       = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             dist_valid,
    input  logic [WIDTH-1:0] dist_in,
    input  logic             cal_req,
    input  logic             peak_clr,
    output logic             height_valid,
    output logic [WIDTH-1:0] height_out,
    output logic [WIDTH-1:0] peak_out,
    output logic [WIDTH-1:0] ground_out,
    output logic             out_of_range,
    output logic             cal_busy
);

    localparam int N      = 1 << AVG_LOG2;
    localparam int SUM_W  = WIDTH + AVG_LOG2;
    localparam int FILL_W = AVG_LOG2 + 1;

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_CAL = 1'b1
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_ground;
    logic [WIDTH-1:0]     r_win [0:N-1];
    logic [SUM_W-1:0]     r_sum;
    logic [AVG_LOG2-1:0]  r_wptr;
    logic [FILL_W-1:0]    r_fill;
    logic [SUM_W-1:0]     r_cal_sum;
    logic [AVG_LOG2-1:0]  r_cal_cnt;
    logic [WIDTH-1:0]     r_height;
    logic [WIDTH-1:0]     r_peak;
    logic                 r_hvalid;
    logic                 r_oor;
    logic                 r_cal_busy;

    logic                 w_over;
    logic [WIDTH-1:0]     w_raw;
    logic [SUM_W-1:0]     w_new_sum;
    logic [WIDTH-1:0]     w_new_height;
    logic                 w_fills;
    logic [FILL_W-1:0]    w_fill_next;
    logic [SUM_W-1:0]     w_cal_sum_next;
    logic                 w_cal_last;

    // A sample further away than the ground contributes zero height.
    assign w_over = (dist_in > r_ground);
    assign w_raw  = w_over ? {WIDTH{1'b0}} : (r_ground - dist_in);

    // The oldest entry is the one about to be overwritten; unfilled slots are
    // zero, so the same update holds while the window is still filling.
    assign w_new_sum    = r_sum + {{AVG_LOG2{1'b0}}, w_raw} - {{AVG_LOG2{1'b0}}, r_win[r_wptr]};
    assign w_new_height = w_new_sum[SUM_W-1:AVG_LOG2];

    // The window counts as full from the sample that completes it onward.
    assign w_fills     = (r_fill >= FILL_W'(N - 1));
    assign w_fill_next = (r_fill == FILL_W'(N)) ? r_fill : (r_fill + FILL_W'(1));

    assign w_cal_sum_next = r_cal_sum + {{AVG_LOG2{1'b0}}, dist_in};
    assign w_cal_last     = (r_cal_cnt == AVG_LOG2'(N - 1));

    // Mode FSM plus the filter, peak and calibration datapath; all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_RUN;
            r_ground   <= WIDTH'(DEFAULT_GROUND);
            for (int i = 0; i < N; i++) begin
                r_win[i] <= {WIDTH{1'b0}};
            end
            r_sum      <= {SUM_W{1'b0}};
            r_wptr     <= {AVG_LOG2{1'b0}};
            r_fill     <= {FILL_W{1'b0}};
            r_cal_sum  <= {SUM_W{1'b0}};
            r_cal_cnt  <= {AVG_LOG2{1'b0}};
            r_height   <= {WIDTH{1'b0}};
            r_peak     <= {WIDTH{1'b0}};
            r_hvalid   <= 1'b0;
            r_oor      <= 1'b0;
            r_cal_busy <= 1'b0;
        end else begin
            r_hvalid <= 1'b0;
            r_oor    <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (cal_req) begin
                        // Calibration wins; any coincident sample is dropped.
                        r_state    <= ST_CAL;
                        r_cal_busy <= 1'b1;
                        r_cal_sum  <= {SUM_W{1'b0}};
                        r_cal_cnt  <= {AVG_LOG2{1'b0}};
                        if (peak_clr) begin
                            r_peak <= {WIDTH{1'b0}};
                        end else begin
                            r_peak <= r_peak;
                        end
                    end else if (dist_valid) begin
                        r_win[r_wptr] <= w_raw;
                        r_sum         <= w_new_sum;
                        r_wptr        <= r_wptr + AVG_LOG2'(1);
                        r_fill        <= w_fill_next;
                        r_oor         <= w_over;
                        if (w_fills) begin
                            r_height <= w_new_height;
                            r_hvalid <= 1'b1;
                            if (peak_clr || (w_new_height > r_peak)) begin
                                r_peak <= w_new_height;
                            end else begin
                                r_peak <= r_peak;
                            end
                        end else begin
                            if (peak_clr) begin
                                r_peak <= {WIDTH{1'b0}};
                            end else begin
                                r_peak <= r_peak;
                            end
                        end
                    end else begin
                        if (peak_clr) begin
                            r_peak <= {WIDTH{1'b0}};
                        end else begin
                            r_peak <= r_peak;
                        end
                    end
                end
                ST_CAL: begin
                    if (dist_valid) begin
                        if (w_cal_last) begin
                            // The new ground invalidates every stored height.
                            r_ground   <= w_cal_sum_next[SUM_W-1:AVG_LOG2];
                            r_state    <= ST_RUN;
                            r_cal_busy <= 1'b0;
                            for (int i = 0; i < N; i++) begin
                                r_win[i] <= {WIDTH{1'b0}};
                            end
                            r_sum      <= {SUM_W{1'b0}};
                            r_wptr     <= {AVG_LOG2{1'b0}};
                            r_fill     <= {FILL_W{1'b0}};
                            r_peak     <= {WIDTH{1'b0}};
                            r_cal_sum  <= {SUM_W{1'b0}};
                            r_cal_cnt  <= {AVG_LOG2{1'b0}};
                        end else begin
                            r_cal_sum <= w_cal_sum_next;
                            r_cal_cnt <= r_cal_cnt + AVG_LOG2'(1);
                            if (peak_clr) begin
                                r_peak <= {WIDTH{1'b0}};
                            end else begin
                                r_peak <= r_peak;
                            end
                        end
                    end else begin
                        if (peak_clr) begin
                            r_peak <= {WIDTH{1'b0}};
                        end else begin
                            r_peak <= r_peak;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_cal_busy <= 1'b0;
                end
            endcase
        end
    end

    assign height_valid = r_hvalid;
    assign height_out   = r_height;
    assign peak_out     = r_peak;
    assign ground_out   = r_ground;
    assign out_of_range = r_oor;
    assign cal_busy     = r_cal_busy;

endmodule

// File: tb/tb_height_filter.sv
// Directed bench for height_filter. The expected values are worked out by hand
// for the default parameters: WIDTH=8, DEFAULT_GROUND=72, N=4.
module tb_height_filter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       dist_valid;
    logic [7:0] dist_in;
    logic       cal_req;
    logic       peak_clr;
    logic       height_valid;
    logic [7:0] height_out;
    logic [7:0] peak_out;
    logic [7:0] ground_out;
    logic       out_of_range;
    logic       cal_busy;

    int checks = 0;
    int errors = 0;

    height_filter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .dist_valid   (dist_valid),
        .dist_in      (dist_in),
        .cal_req      (cal_req),
        .peak_clr     (peak_clr),
        .height_valid (height_valid),
        .height_out   (height_out),
        .peak_out     (peak_out),
        .ground_out   (ground_out),
        .out_of_range (out_of_range),
        .cal_busy     (cal_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs; return at posedge+1 with the inputs idle again.
    task automatic step(input logic v, input logic [7:0] d, input logic c, input logic p);
        dist_valid = v;
        dist_in    = d;
        cal_req    = c;
        peak_clr   = p;
        @(posedge clk);
        #1;
        dist_valid = 1'b0;
        dist_in    = 8'd0;
        cal_req    = 1'b0;
        peak_clr   = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        dist_valid = 1'b0;
        dist_in    = 8'd0;
        cal_req    = 1'b0;
        peak_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ground", ground_out, 72);
        chk("rst_height", height_out, 0);
        chk("rst_peak", peak_out, 0);
        chk("rst_hvalid", height_valid, 0);
        chk("rst_oor", out_of_range, 0);
        chk("rst_busy", cal_busy, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: four samples of 40 give a height of 32
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'd40, 1'b0, 1'b0);
            chk("t1_nofill_valid", height_valid, 0);
            chk("t1_nofill_height", height_out, 0);
        end
        step(1'b1, 8'd40, 1'b0, 1'b0);
        chk("t1_valid", height_valid, 1);
        chk("t1_height", height_out, 32);
        chk("t1_peak", peak_out, 32);
        chk("t1_oor", out_of_range, 0);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        chk("t1_valid_single", height_valid, 0);

        // 2: a sample beyond the ground counts as height 0 and flags out_of_range
        step(1'b1, 8'd80, 1'b0, 1'b0);
        chk("t2_oor", out_of_range, 1);
        chk("t2_valid", height_valid, 1);
        chk("t2_height", height_out, 24);
        chk("t2_peak", peak_out, 32);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        chk("t2_oor_single", out_of_range, 0);

        // 3: calibrate on 60..63, which gives a ground of 61
        step(1'b0, 8'd0, 1'b1, 1'b0);
        chk("t3_busy_start", cal_busy, 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'(60 + i), 1'b0, 1'b0);
            chk("t3_busy_mid", cal_busy, 1);
            chk("t3_no_valid", height_valid, 0);
        end
        step(1'b1, 8'd63, 1'b0, 1'b0);
        chk("t3_busy_end", cal_busy, 0);
        chk("t3_ground", ground_out, 61);
        chk("t3_peak", peak_out, 0);
        chk("t3_height_hold", height_out, 24);

        // 4: refill at 32 (dist 29), then clear the peak together with a sample and on its own
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'd29, 1'b0, 1'b0);
            chk("t4_refill_nv", height_valid, 0);
        end
        step(1'b1, 8'd29, 1'b0, 1'b0);
        chk("t4_height32", height_out, 32);
        chk("t4_peak32", peak_out, 32);
        step(1'b1, 8'd61, 1'b0, 1'b0);
        chk("t4_height24", height_out, 24);
        step(1'b1, 8'd61, 1'b0, 1'b0);
        chk("t4_height16", height_out, 16);
        chk("t4_peak_kept", peak_out, 32);
        step(1'b1, 8'd13, 1'b0, 1'b1);
        chk("t4_height20", height_out, 20);
        chk("t4_peak_clr_new", peak_out, 20);
        step(1'b0, 8'd0, 1'b0, 1'b1);
        chk("t4_peak_clr_bare", peak_out, 0);

        // 5: reset in the middle of a calibration
        step(1'b0, 8'd0, 1'b1, 1'b0);
        step(1'b1, 8'd5, 1'b0, 1'b0);
        step(1'b1, 8'd5, 1'b0, 1'b0);
        chk("t5_busy_pre", cal_busy, 1);
        reset_n = 1'b0;
        #1;
        chk("t5_ground", ground_out, 72);
        chk("t5_busy", cal_busy, 0);
        chk("t5_height", height_out, 0);
        chk("t5_peak", peak_out, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // 6: boundaries -- dist=ground gives 0 with no flag, dist=0 gives 72
        step(1'b1, 8'd72, 1'b0, 1'b0);
        chk("t6_eq_oor", out_of_range, 0);
        chk("t6_eq_nv", height_valid, 0);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 8'd0, 1'b0, 1'b0);
        end
        step(1'b1, 8'd0, 1'b0, 1'b0);
        chk("t6_valid", height_valid, 1);
        chk("t6_height", height_out, 54);
        chk("t6_peak", peak_out, 54);
        // a sample that arrives with cal_req is dropped, so no flag and no calibration count
        step(1'b1, 8'd100, 1'b1, 1'b0);
        chk("t6_coinc_busy", cal_busy, 1);
        chk("t6_coinc_oor", out_of_range, 0);
        chk("t6_coinc_nv", height_valid, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'd10, 1'b0, 1'b0);
        end
        chk("t6_busy_after3", cal_busy, 1);
        step(1'b1, 8'd10, 1'b0, 1'b0);
        chk("t6_busy_done", cal_busy, 0);
        chk("t6_ground10", ground_out, 10);
        chk("t6_height_hold", height_out, 54);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
